// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: merges PS/2 keys and joystick words into player inputs.
// Optional: define INPUT_SOCD_EN to cancel opposite directions per player.
module arcade_input_ctrl #(
  parameter int PLAYERS    = 2,
  parameter int BUTTONS    = 3,
  parameter int COIN_PULSE = 1920000,
  parameter int DIP_BANKS  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [10:0]                    ps2_key,
  input  logic [PLAYERS*(7+BUTTONS)-1:0] joystick,
  input  logic                           ioctl_wr,
  input  logic [7:0]                     ioctl_index,
  input  logic [24:0]                    ioctl_addr,
  input  logic [7:0]                     ioctl_data,
  output logic [PLAYERS*4-1:0]           joy,
  output logic [PLAYERS*BUTTONS-1:0]     buttons,
  output logic [PLAYERS-1:0]             start,
  output logic [PLAYERS-1:0]             coin,
  output logic                           pause,
  output logic [DIP_BANKS*8-1:0]         dip
);

  localparam int JW = 7 + BUTTONS;
  localparam int CW = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(COIN_PULSE - 1);

  typedef enum logic [2:0] {
    K_NONE, K_DIR, K_BTN, K_START, K_COIN, K_PAUSE
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [1:0] pl;
    logic [2:0] ix;
  } kmap_t;

  // Scan code to (kind, player, index); dir index is the joy bit position.
  function automatic kmap_t kmap(input logic [7:0] code);
    kmap_t m;
    m = '{K_NONE, 2'd0, 3'd0};
    case (code)
      8'h75: m = '{K_DIR, 2'd0, 3'd3};
      8'h72: m = '{K_DIR, 2'd0, 3'd2};
      8'h74: m = '{K_DIR, 2'd0, 3'd1};
      8'h6B: m = '{K_DIR, 2'd0, 3'd0};
      8'h14: m = '{K_BTN, 2'd0, 3'd0};
      8'h11: m = '{K_BTN, 2'd0, 3'd1};
      8'h29: m = '{K_BTN, 2'd0, 3'd2};
      8'h12: m = '{K_BTN, 2'd0, 3'd3};
      8'h1A: m = '{K_BTN, 2'd0, 3'd4};
      8'h22: m = '{K_BTN, 2'd0, 3'd5};
      8'h21: m = '{K_BTN, 2'd0, 3'd6};
      8'h2A: m = '{K_BTN, 2'd0, 3'd7};
      8'h16: m = '{K_START, 2'd0, 3'd0};
      8'h2E: m = '{K_COIN, 2'd0, 3'd0};
      8'h4D: m = '{K_PAUSE, 2'd0, 3'd0};
      8'h2D: m = '{K_DIR, 2'd1, 3'd3};
      8'h2B: m = '{K_DIR, 2'd1, 3'd2};
      8'h34: m = '{K_DIR, 2'd1, 3'd1};
      8'h23: m = '{K_DIR, 2'd1, 3'd0};
      8'h1C: m = '{K_BTN, 2'd1, 3'd0};
      8'h1B: m = '{K_BTN, 2'd1, 3'd1};
      8'h15: m = '{K_BTN, 2'd1, 3'd2};
      8'h1D: m = '{K_BTN, 2'd1, 3'd3};
      8'h24: m = '{K_BTN, 2'd1, 3'd4};
      8'h2C: m = '{K_BTN, 2'd1, 3'd5};
      8'h35: m = '{K_BTN, 2'd1, 3'd6};
      8'h3C: m = '{K_BTN, 2'd1, 3'd7};
      8'h1E: m = '{K_START, 2'd1, 3'd0};
      8'h36: m = '{K_COIN, 2'd1, 3'd0};
      8'h26: m = '{K_START, 2'd2, 3'd0};
      8'h3D: m = '{K_COIN, 2'd2, 3'd0};
      8'h25: m = '{K_START, 2'd3, 3'd0};
      8'h3E: m = '{K_COIN, 2'd3, 3'd0};
      default: m = '{K_NONE, 2'd0, 3'd0};
    endcase
    return m;
  endfunction

  logic               tog;
  logic [3:0]         kdir [PLAYERS];
  logic [BUTTONS-1:0] kbtn [PLAYERS];
  logic [PLAYERS-1:0] kst;
  logic [PLAYERS-1:0] kcn;
  logic               kps;
  kmap_t              km;
  logic               ev;
  logic               unused_ext;

  assign km         = kmap(ps2_key[7:0]);
  assign ev         = ps2_key[10] != tog;
  assign unused_ext = ps2_key[8];

  // Key state registers, updated on each toggle event.
  always_ff @(posedge clk) begin
    if (reset) begin
      tog <= ps2_key[10];
      kst <= '0;
      kcn <= '0;
      kps <= 1'b0;
      for (int p = 0; p < PLAYERS; p++) begin
        kdir[p] <= '0;
        kbtn[p] <= '0;
      end
    end else begin
      tog <= ps2_key[10];
      if (ev) begin
        for (int p = 0; p < PLAYERS; p++) begin
          if (km.pl == 2'(p)) begin
            unique case (km.kind)
              K_DIR:   kdir[p][km.ix[1:0]] <= ps2_key[9];
              K_BTN: begin
                for (int b = 0; b < BUTTONS; b++)
                  if (km.ix == 3'(b)) kbtn[p][b] <= ps2_key[9];
              end
              K_START: kst[p] <= ps2_key[9];
              K_COIN:  kcn[p] <= ps2_key[9];
              default: ;
            endcase
          end
        end
        if (km.kind == K_PAUSE) kps <= ps2_key[9];
      end
    end
  end

  logic [PLAYERS*4-1:0]       dir_raw;
  logic [PLAYERS*BUTTONS-1:0] btn_raw;
  logic [PLAYERS-1:0]         st_raw;
  logic [PLAYERS-1:0]         cn_raw;
  logic                       ps_raw;

  // Merge key state with joystick bits into raw per-player sources.
  always_comb begin
    dir_raw = '0;
    btn_raw = '0;
    st_raw  = '0;
    cn_raw  = '0;
    ps_raw  = kps;
    for (int p = 0; p < PLAYERS; p++) begin
      dir_raw[p*4 +: 4] = kdir[p] | {joystick[p*JW+3],
                                     joystick[p*JW+2],
                                     joystick[p*JW+0],
                                     joystick[p*JW+1]};
`ifdef INPUT_SOCD_EN
      if (dir_raw[p*4+3] && dir_raw[p*4+2])
        dir_raw[p*4+2 +: 2] = 2'b00;
      if (dir_raw[p*4+1] && dir_raw[p*4+0])
        dir_raw[p*4 +: 2] = 2'b00;
`endif
      btn_raw[p*BUTTONS +: BUTTONS] =
        kbtn[p] | joystick[p*JW+4 +: BUTTONS];
      st_raw[p] = kst[p] | joystick[p*JW+4+BUTTONS];
      cn_raw[p] = kcn[p] | joystick[p*JW+5+BUTTONS];
      ps_raw    = ps_raw | joystick[p*JW+6+BUTTONS];
    end
  end

  logic [PLAYERS-1:0] cn_q;
  logic               ps_q;
  logic [CW-1:0]      cnt [PLAYERS];

  // Output registers, coin stretch counters and pause toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      joy     <= '0;
      buttons <= '0;
      start   <= '0;
      coin    <= '0;
      pause   <= 1'b0;
      cn_q    <= '0;
      ps_q    <= 1'b0;
      for (int p = 0; p < PLAYERS; p++) cnt[p] <= '0;
    end else begin
      joy     <= dir_raw;
      buttons <= btn_raw;
      start   <= st_raw;
      cn_q    <= cn_raw;
      ps_q    <= ps_raw;
      if (ps_raw && !ps_q) pause <= !pause;
      for (int p = 0; p < PLAYERS; p++) begin
        if (cn_raw[p] && !cn_q[p])
          cnt[p] <= RELOAD;
        else if (cnt[p] != '0)
          cnt[p] <= cnt[p] - CW'(1);
        coin[p] <= cn_raw[p] | (cnt[p] != '0);
      end
    end
  end

  logic [DIP_BANKS*8-1:0] dip_q = '0;

  // DIP banks survive reset; only menu downloads change them.
  always_ff @(posedge clk) begin
    if (ioctl_wr && ioctl_index == 8'd254) begin
      for (int n = 0; n < DIP_BANKS; n++)
        if (ioctl_addr == 25'(n)) dip_q[n*8 +: 8] <= ioctl_data;
    end
  end

  assign dip = dip_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// tb_arcade_input_ctrl: randomized and directed checks against a
// scan-code-table reference model of the input front end.
module tb_arcade_input_ctrl;

  localparam int P   = 4;
  localparam int B   = 6;
  localparam int CP  = 8;
  localparam int DB  = 8;
  localparam int JW  = 7 + B;
  localparam int JWT = P * JW;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [10:0]    ps2_key = '0;
  logic [JWT-1:0] joystick = '0;
  logic           ioctl_wr = 1'b0;
  logic [7:0]     ioctl_index = '0;
  logic [24:0]    ioctl_addr = '0;
  logic [7:0]     ioctl_data = '0;
  logic [P*4-1:0] joy;
  logic [P*B-1:0] buttons;
  logic [P-1:0]   start;
  logic [P-1:0]   coin;
  logic           pause;
  logic [DB*8-1:0] dip;

  int vectors = 0;
  int errors  = 0;

  arcade_input_ctrl #(
    .PLAYERS(P), .BUTTONS(B), .COIN_PULSE(CP), .DIP_BANKS(DB)
  ) dut (
    .clk(clk), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
    .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .joy(joy), .buttons(buttons), .start(start), .coin(coin),
    .pause(pause), .dip(dip)
  );

  always #5 clk = ~clk;

  logic [7:0] up_c [2] = '{8'h75, 8'h2D};
  logic [7:0] dn_c [2] = '{8'h72, 8'h2B};
  logic [7:0] lf_c [2] = '{8'h6B, 8'h23};
  logic [7:0] rt_c [2] = '{8'h74, 8'h34};
  logic [7:0] bt_c [2][8] = '{
    '{8'h14, 8'h11, 8'h29, 8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A},
    '{8'h1C, 8'h1B, 8'h15, 8'h1D, 8'h24, 8'h2C, 8'h35, 8'h3C}};
  logic [7:0] st_c [4] = '{8'h16, 8'h1E, 8'h26, 8'h25};
  logic [7:0] pool [30] = '{
    8'h75, 8'h72, 8'h6B, 8'h74, 8'h2D, 8'h2B, 8'h23, 8'h34,
    8'h14, 8'h11, 8'h29, 8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,
    8'h1C, 8'h1B, 8'h15, 8'h1D, 8'h24, 8'h2C, 8'h35, 8'h3C,
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h99, 8'h00};

  bit kst [256];
  logic [DB*8-1:0] exp_dip = '0;

  function automatic logic [P*4-1:0] exp_joy();
    logic [P*4-1:0] r;
    logic u, d, l, rt;
    r = '0;
    for (int p = 0; p < P; p++) begin
      rt = joystick[p*JW+0];
      l  = joystick[p*JW+1];
      d  = joystick[p*JW+2];
      u  = joystick[p*JW+3];
      if (p < 2) begin
        u  = u  | kst[up_c[p]];
        d  = d  | kst[dn_c[p]];
        l  = l  | kst[lf_c[p]];
        rt = rt | kst[rt_c[p]];
      end
`ifdef INPUT_SOCD_EN
      if (u && d) begin u = 1'b0; d = 1'b0; end
      if (l && rt) begin l = 1'b0; rt = 1'b0; end
`endif
      r[p*4 +: 4] = {u, d, rt, l};
    end
    return r;
  endfunction

  function automatic logic [P*B-1:0] exp_btn();
    logic [P*B-1:0] r;
    r = '0;
    for (int p = 0; p < P; p++)
      for (int b = 0; b < B; b++) begin
        r[p*B+b] = joystick[p*JW+4+b];
        if (p < 2) r[p*B+b] = r[p*B+b] | kst[bt_c[p][b]];
      end
    return r;
  endfunction

  function automatic logic [P-1:0] exp_start();
    logic [P-1:0] r;
    for (int p = 0; p < P; p++)
      r[p] = joystick[p*JW+4+B] | kst[st_c[p]];
    return r;
  endfunction

  function automatic logic [JWT-1:0] jmask();
    logic [JWT-1:0] m;
    m = '1;
    for (int p = 0; p < P; p++) begin
      m[p*JW+5+B] = 1'b0;
      m[p*JW+6+B] = 1'b0;
    end
    return m;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input logic [7:0] code, input logic pr);
    ps2_key = {~ps2_key[10], pr, 1'b0, code};
    kst[code] = pr;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    foreach (kst[i]) kst[i] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);
    if (joy !== '0) begin
      $display("FAIL reset_joy: got %h want 0", joy); errors++;
    end
    vectors++;
    if (buttons !== '0) begin
      $display("FAIL reset_buttons: got %h want 0", buttons); errors++;
    end
    vectors++;
    if (start !== '0 || coin !== '0) begin
      $display("FAIL reset_start_coin: got %h/%h want 0/0", start, coin);
      errors++;
    end
    vectors++;
    if (pause !== 1'b0) begin
      $display("FAIL reset_pause: got %b want 0", pause); errors++;
    end
    vectors++;
    if (dip !== '0) begin
      $display("FAIL powerup_dip: got %h want 0", dip); errors++;
    end
    vectors++;
  endtask

  task automatic test_key_latency();
    key(8'h75, 1'b1);
    tick();
    if (joy[3] !== 1'b0) begin
      $display("FAIL press_early: got %b want 0", joy[3]); errors++;
    end
    vectors++;
    tick();
    if (joy[3] !== 1'b1) begin
      $display("FAIL press_lat2: got %b want 1", joy[3]); errors++;
    end
    vectors++;
    key(8'h75, 1'b0);
    tick();
    if (joy[3] !== 1'b1) begin
      $display("FAIL release_early: got %b want 1", joy[3]); errors++;
    end
    vectors++;
    tick();
    if (joy[3] !== 1'b0) begin
      $display("FAIL release_lat2: got %b want 0", joy[3]); errors++;
    end
    vectors++;
  endtask

  task automatic test_random_merge();
    logic [JWT-1:0] m;
    logic [P*4-1:0] ej;
    logic [P*B-1:0] eb;
    logic [P-1:0]   es;
    m = jmask();
    for (int i = 0; i < 80; i++) begin
      key(pool[$urandom_range(29)], 1'($urandom_range(1)));
      joystick = JWT'({$urandom, $urandom}) & m;
      tick(3);
      ej = exp_joy();
      eb = exp_btn();
      es = exp_start();
      if (joy !== ej) begin
        $display("FAIL rand_joy[%0d]: got %h want %h", i, joy, ej); errors++;
      end
      vectors++;
      if (buttons !== eb) begin
        $display("FAIL rand_btn[%0d]: got %h want %h", i, buttons, eb);
        errors++;
      end
      vectors++;
      if (start !== es) begin
        $display("FAIL rand_start[%0d]: got %h want %h", i, start, es);
        errors++;
      end
      vectors++;
    end
    joystick = '0;
    apply_reset();
  endtask

  task automatic test_socd();
    logic [1:0] e;
`ifdef INPUT_SOCD_EN
    e = 2'b00;
`else
    e = 2'b11;
`endif
    key(8'h6B, 1'b1);
    joystick[0] = 1'b1;
    tick(3);
    if (joy[1:0] !== e) begin
      $display("FAIL socd_lr: got %b want %b", joy[1:0], e); errors++;
    end
    vectors++;
    key(8'h6B, 1'b0);
    joystick = '0;
    tick(3);
    key(8'h2D, 1'b1);
    tick(2);
    key(8'h2B, 1'b1);
    tick(3);
    if (joy[7:6] !== e) begin
      $display("FAIL socd_ud: got %b want %b", joy[7:6], e); errors++;
    end
    vectors++;
    key(8'h2D, 1'b0);
    tick(2);
    key(8'h2B, 1'b0);
    tick(3);
  endtask

  task automatic test_players34();
    key(8'h26, 1'b1);
    tick(2);
    if (start !== 4'b0100) begin
      $display("FAIL p3_start: got %b want 0100", start); errors++;
    end
    vectors++;
    key(8'h26, 1'b0);
    tick(3);
    key(8'h2A, 1'b1);
    tick(3);
    if (buttons !== '0 || joy !== '0) begin
      $display("FAIL btn8_ignored: got %h/%h want 0/0", buttons, joy);
      errors++;
    end
    vectors++;
    key(8'h2A, 1'b0);
    tick(3);
  endtask

  task automatic coin_run(input string nm, input int pl,
                          input logic [63:0] pat, input int total);
    int   bi;
    int   high;
    logic e;
    bi = pl * JW + 5 + B;
    high = 0;
    for (int i = 0; i < 64; i++) begin
      joystick[bi] = pat[i];
      tick();
      e = pat[i];
      for (int k = 0; k < CP; k++) begin
        if (i - k >= 0)
          if (pat[i-k] && (i - k == 0 || !pat[i-k-1])) e = 1'b1;
      end
      if (coin[pl] !== e) begin
        $display("FAIL %s[%0d]: got %b want %b", nm, i, coin[pl], e);
        errors++;
      end
      vectors++;
      high += int'(coin[pl]);
    end
    if (total >= 0) begin
      if (high != total) begin
        $display("FAIL %s_len: got %0d want %0d", nm, high, total);
        errors++;
      end
      vectors++;
    end
    joystick[bi] = 1'b0;
    tick(CP + 2);
  endtask

  task automatic test_coin();
    coin_run("coin_pulse", 1, 64'h1, CP);
    coin_run("coin_hold", 1, 64'hF_FFFF, 20);
    coin_run("coin_retrig", 1, 64'h11, 4 + CP);
    coin_run("coin_rand", 3, {$urandom, $urandom}, -1);
  endtask

  task automatic test_coin_reset();
    joystick[5+B] = 1'b1;
    tick();
    joystick[5+B] = 1'b0;
    tick(3);
    if (coin[0] !== 1'b1) begin
      $display("FAIL coin_mid: got %b want 1", coin[0]); errors++;
    end
    vectors++;
    reset = 1'b1;
    tick();
    if (coin !== '0) begin
      $display("FAIL coin_reset: got %b want 0", coin); errors++;
    end
    vectors++;
    reset = 1'b0;
    tick();
    if (coin !== '0) begin
      $display("FAIL coin_after_reset: got %b want 0", coin); errors++;
    end
    vectors++;
  endtask

  task automatic test_pause();
    logic ep;
    ep = 1'b0;
    key(8'h4D, 1'b1);
    ep = ~ep;
    tick(3);
    if (pause !== ep) begin
      $display("FAIL pause_press1: got %b want %b", pause, ep); errors++;
    end
    vectors++;
    tick(100);
    if (pause !== ep) begin
      $display("FAIL pause_hold: got %b want %b", pause, ep); errors++;
    end
    vectors++;
    key(8'h4D, 1'b0);
    tick(3);
    if (pause !== ep) begin
      $display("FAIL pause_release: got %b want %b", pause, ep); errors++;
    end
    vectors++;
    key(8'h4D, 1'b1);
    ep = ~ep;
    tick(3);
    if (pause !== ep) begin
      $display("FAIL pause_press2: got %b want %b", pause, ep); errors++;
    end
    vectors++;
    key(8'h4D, 1'b0);
    tick(3);
    joystick[6+B] = 1'b1;
    joystick[JW+6+B] = 1'b1;
    ep = ~ep;
    tick(3);
    if (pause !== ep) begin
      $display("FAIL pause_joy_both: got %b want %b", pause, ep); errors++;
    end
    vectors++;
    joystick = '0;
    tick(3);
    if (pause !== ep) begin
      $display("FAIL pause_joy_rel: got %b want %b", pause, ep); errors++;
    end
    vectors++;
  endtask

  task automatic dip_wr(input logic [7:0] idx, input logic [24:0] addr,
                        input logic [7:0] data);
    ioctl_index = idx;
    ioctl_addr  = addr;
    ioctl_data  = data;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    if (idx == 8'd254 && addr < 25'(DB))
      exp_dip[int'(addr)*8 +: 8] = data;
    if (dip !== exp_dip) begin
      $display("FAIL dip_wr %0d/%0d: got %h want %h", idx, addr, dip,
               exp_dip);
      errors++;
    end
    vectors++;
  endtask

  task automatic test_dip();
    dip_wr(8'd254, 25'd0, 8'hA5);
    dip_wr(8'd254, 25'd1, 8'h3C);
    dip_wr(8'd254, 25'd8, 8'hFF);
    dip_wr(8'd253, 25'd2, 8'h77);
    for (int i = 0; i < 12; i++)
      dip_wr($urandom_range(1) ? 8'd254 : 8'($urandom_range(255)),
             25'($urandom_range(15)), 8'($urandom_range(255)));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    if (dip !== exp_dip) begin
      $display("FAIL dip_keep: got %h want %h", dip, exp_dip); errors++;
    end
    vectors++;
  endtask

  initial begin
    tick();
    test_reset();
    test_key_latency();
    test_random_merge();
    test_socd();
    test_players34();
    test_coin();
    test_coin_reset();
    test_pause();
    test_dip();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
